cnn_line_buffer: RTL
====================

CNN_LINE_BUFFER -- requirements
Module: cnn_line_buffer

Interface
REQ-001 SHALL have parameter KX, default 5, kernel width in pixels.
REQ-002 SHALL have parameter KY, default 5, kernel height in rows.
REQ-003 SHALL have parameter I_F_BW, default 8, input pixel bit width.
REQ-004 SHALL have parameter IMG_W, default 28, image width in pixels.
REQ-005 SHALL have parameter IMG_H, default 28, image height in rows.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port i_in_valid, input, 1, pixel qualifier; a pixel is accepted on every cycle it is high.
REQ-009 SHALL have port i_in_pixel, input, I_F_BW, pixel value in raster order (row-major, col 0 first).
REQ-010 SHALL have port o_ot_valid, output, 1, window qualifier, one-cycle pulse per window.
REQ-011 SHALL have port o_ot_fmap, output, KX*KY*I_F_BW, packed window for the downstream cnn_kernel i_in_fmap.
REQ-012 SHALL have port o_frame_done, output, 1, one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-013 SHALL keep col counter (0..IMG_W-1) and row counter (0..IMG_H-1), advanced only on accepted pixels.
REQ-014 SHALL wrap col to 0 and increment row after col=IMG_W-1; after (IMG_W-1, IMG_H-1), SHALL wrap both to 0 (next frame).
REQ-015 SHALL hold KY-1 row delay lines of IMG_W entries each, plus a KX-by-KY window register, all shifted only on accepted pixels.
REQ-016 SHALL hold all state (counters, delay lines, window) unchanged on cycles with i_in_valid=0.
REQ-017 SHALL pack window element (ky,kx) at o_ot_fmap[(ky*KX+kx)*I_F_BW +: I_F_BW], where ky=0 is the oldest (top) row and kx=0 the leftmost (oldest) column.
REQ-018 SHALL use a two-state FSM: FILL (row < KY-1, no output) and RUN (row >= KY-1); FILL->RUN on acceptance of pixel (IMG_W-1, KY-2); RUN->FILL on frame wrap.
REQ-019 SHALL assert o_ot_valid exactly one cycle after accepting a pixel at (col,row) with col>=KX-1 and state RUN; the window then covers rows row-KY+1..row and cols col-KX+1..col.
REQ-020 SHALL never assert o_ot_valid for col<KX-1, so no window straddles a row boundary.
REQ-021 SHALL emit exactly (IMG_W-KX+1)*(IMG_H-KY+1) windows per frame (576 at defaults).
REQ-022 SHALL register o_ot_fmap and hold it stable between valid pulses.
REQ-023 SHALL assert o_frame_done one cycle after accepting pixel (IMG_W-1, IMG_H-1), coincident with that frame's last o_ot_valid.
REQ-024 SHALL accept back-to-back pixels (one per cycle) with no backpressure; throughput 1 pixel/cycle.

Reset
REQ-025 SHALL on reset set counters to 0, FSM to FILL, o_ot_valid=0, o_frame_done=0, o_ot_fmap=0.
REQ-026 SHALL NOT require delay-line contents to be cleared; stale data is never exposed because FILL re-primes them.
REQ-027 SHALL, on reset mid-frame, discard the partial frame; the first pixel after release is (0,0).

Structure
REQ-028 SHALL take KX, KY, I_F_BW, IMG_W, IMG_H defaults from the shared cnn_defines package/header used by cnn_kernel.
REQ-029 SHALL instantiate KY-1 copies of sub-module cnn_line_delay (IMG_W-deep, I_F_BW-wide, enable-gated shift, inferrable as RAM or SRL).

Verification (pixel value = (row*IMG_W+col) mod 256, defaults)
REQ-030 SHALL check: continuous full frame -> first o_ot_valid one cycle after pixel index 116; window elements = 0..4, 28..32, 56..60, 84..88, 112..116; element 12 = 58.
REQ-031 SHALL check: full frame -> 576 valid pulses, none following a col 0..3 pixel, o_frame_done once with last window (center element = (25*28+25) mod 256 = 213).
REQ-032 SHALL check: random i_in_valid gaps (50% duty) -> identical window sequence and count to the continuous case.
REQ-033 SHALL check: two back-to-back frames -> second frame emits no window until its row 4, col 4; windows match the first frame.
REQ-034 SHALL check: reset asserted after pixel 300 -> outputs 0 immediately; next frame produces the REQ-030 first window exactly.

Source files
------------

// File: rtl/cnn_defines.sv
// rtl/cnn_defines.sv - shared CNN geometry defaults and line-buffer FSM state type
package cnn_defines;

    localparam int CNN_KX     = 5;
    localparam int CNN_KY     = 5;
    localparam int CNN_I_F_BW = 8;
    localparam int CNN_IMG_W  = 28;
    localparam int CNN_IMG_H  = 28;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } lb_state_t;

endpackage

// File: rtl/cnn_line_delay.sv
// rtl/cnn_line_delay.sv - enable-gated DEPTH-sample delay line built as a circular buffer
module cnn_line_delay #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

    // Contents carry no reset so the array maps onto block RAM or SRLs.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    // The slot about to be overwritten holds the sample from DEPTH accepts ago.
    assign dout = mem[ptr];

endmodule

// File: rtl/cnn_line_buffer.sv
// rtl/cnn_line_buffer.sv - raster pixel stream to KX-by-KY sliding window for cnn_kernel
module cnn_line_buffer
    import cnn_defines::*;
#(
    parameter int KX     = CNN_KX,
    parameter int KY     = CNN_KY,
    parameter int I_F_BW = CNN_I_F_BW,
    parameter int IMG_W  = CNN_IMG_W,
    parameter int IMG_H  = CNN_IMG_H
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_in_valid,
    input  logic [I_F_BW-1:0]         i_in_pixel,
    output logic                      o_ot_valid,
    output logic [KX*KY*I_F_BW-1:0]   o_ot_fmap,
    output logic                      o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    lb_state_t         state;
    lb_state_t         state_nxt;
    logic              emit;
    logic              col_last;
    logic              row_last;
    logic              frame_last;

    logic [I_F_BW-1:0] line_in  [KY-1];
    logic [I_F_BW-1:0] line_out [KY-1];
    logic [I_F_BW-1:0] tap      [KY];
    logic [I_F_BW-1:0] win      [KY][KX];
    logic [I_F_BW-1:0] win_nxt  [KY][KX];
    logic [KX*KY*I_F_BW-1:0] fmap_nxt;

    // Delay lines are chained: line g holds the row that is g+1 rows older than the input.
    genvar g;
    generate
        for (g = 0; g < KY - 1; g++) begin : g_line
            if (g == 0) begin : g_first
                assign line_in[g] = i_in_pixel;
            end else begin : g_chain
                assign line_in[g] = line_out[g-1];
            end
            cnn_line_delay #(
                .DEPTH (IMG_W),
                .WIDTH (I_F_BW)
            ) u_line_delay (
                .clk   (clk),
                .reset (reset),
                .en    (i_in_valid),
                .din   (line_in[g]),
                .dout  (line_out[g])
            );
            assign tap[KY-2-g] = line_out[g];
        end
    endgenerate

    assign tap[KY-1] = i_in_pixel;

    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign frame_last = col_last && row_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (i_in_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            ST_FILL: begin
                if (i_in_valid && col_last && (row == RW'(KY - 2))) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                emit = i_in_valid && (col >= CW'(KX - 1));
                if (i_in_valid && frame_last) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Window shifts left; the new column enters at kx = KX-1 from the delay-line taps.
    always_comb begin
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX - 1; kx++) begin
                win_nxt[ky][kx] = win[ky][kx+1];
            end
            win_nxt[ky][KX-1] = tap[ky];
        end
    end

    always_comb begin
        fmap_nxt = '0;
        for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
                fmap_nxt[(ky*KX+kx)*I_F_BW +: I_F_BW] = win_nxt[ky][kx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            win <= win_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_ot_fmap    <= '0;
        end else begin
            o_ot_valid   <= emit;
            o_frame_done <= i_in_valid && frame_last;
            if (emit) begin
                o_ot_fmap <= fmap_nxt;
            end
        end
    end

endmodule
